histo_readout: RTL and testbench
================================

# histo_readout

Downstream readout stage for the histogram accumulator. After a frame completes it sweeps all bins through the accumulator's bin/data read port, then serializes the counts into a byte stream for the host link. The stream uses a valid/ready handshake, with a header, a per-frame ID, a 32-bit total and an 8-bit checksum. It also holds the accumulator in read mode for the duration of the sweep.

## Interface
- NUM_BINS, 1024: bins swept per packet.
- BIN_W, 10: bin address width.
- COUNT_W, 24: bin count width; fixed at 3 bytes per bin.
- RD_LAT, 2: cycles from a stable `hist_bin` to valid `hist_data` (minimum 1).

- clk  in  1: single clock; all logic on rising edge.
- rst_n  in  1: reset, asynchronous and active-low.
- start  in  1: one-cycle pulse at end of frame, tied to the accumulator's `image_done`.
- busy  out  1: high from the cycle after `start` is accepted until the cycle the last byte is accepted.
- done  out  1: one-cycle pulse, the cycle after the last byte is accepted.
- hist_rw  out  1: accumulator mode; 1 = accumulate, 0 = read.
- hist_bin  out  BIN_W: bin address to the accumulator.
- hist_data  in  COUNT_W: bin count returned by the accumulator.
- m_data  out  8: stream byte.
- m_valid  out  1: `m_data` is valid.
- m_ready  in  1: downstream accepts the byte; a transfer occurs when `m_valid & m_ready`.
- m_last  out  1: high with the final byte (checksum).

## Operation
- Packet format, 3080 bytes in this order:
  - 0xA5, 0x5A
  - frame_id
  - for bins 0..1023: each count as 3 bytes, MSB first
  - sum of all counts mod 2^32, as 4 bytes MSB first
  - checksum = sum mod 256 of every byte from frame_id through the last sum byte
- States:
  - IDLE: `start` moves to HDR.
  - HDR: three bytes; after the third transfer, goes to FETCH with idx=0.
  - FETCH: drives `hist_bin`=idx, `m_valid`=0, waits RD_LAT cycles, captures `hist_data`, then goes to SEND.
  - SEND: three bytes. After the third transfer, goes to FETCH with idx+1, or to TAIL if idx = NUM_BINS-1.
  - TAIL: four sum bytes.
  - CSUM: one byte, with `m_last`=1. On transfer: pulse `done`, increment frame_id, return to IDLE.
- `start` is ignored when not in IDLE, including `start` asserted in the same cycle as `done`.
- `hist_rw` is 0 in every non-IDLE state and 1 in IDLE.
- The sum accumulator is 32 bits, adds each captured count and wraps. It clears on start acceptance.
- The checksum accumulator is 8 bits, adds each transferred byte from frame_id onward and wraps. It clears on start acceptance.
- frame_id is 8 bits, wraps 255->0, and is sampled into the header at start acceptance.
- Backpressure: while `m_valid & !m_ready`, `m_data`, `m_last` and the state hold stable. `m_valid` never deasserts before a transfer completes.
- Reset values: busy=0, done=0, hist_rw=1, hist_bin=0, m_data=0, m_valid=0, m_last=0, frame_id=0, state IDLE.
- Asserting `rst_n` low mid-packet aborts the packet immediately and no partial checksum byte is emitted. The next `start` begins a fresh packet with frame_id=0.

## Timing
- `start` at cycle T: busy=1, hist_rw=0 and m_valid=1 (byte 0xA5) at T+1.
- With `m_ready` held high:
  - each bin takes RD_LAT+3 cycles;
  - full packet: 3 + 1024*(RD_LAT+3) + 5 transfer/fetch cycles = 5128 for RD_LAT=2;
  - `done` at T+5129.
- `hist_data` is captured exactly RD_LAT cycles after `hist_bin` is updated. `hist_bin` holds constant through SEND of that bin.
- No combinational path from `m_ready` to `m_valid`. `m_ready` may gate state advance combinationally.

## Test plan
- All bins zero, m_ready=1: stream is A5 5A 00, then 3072×00, then 00 00 00 00, then 00. `m_last` only on byte 3080; `done` one cycle later.
- Bin k = k: count bytes match k MSB-first, sum bytes 00 07 FE 00, checksum equal to the software model; `hist_bin` increments 0..1023 exactly once each.
- All bins 0xFFFFFF: sum bytes FF FF FC 00 (wrap of 0x3FFFFFC00); checksum matches model.
- Bin k = k with m_ready randomized at 50%: byte sequence identical to the m_ready=1 run; `m_data` stable on every stalled cycle; `hist_rw`=0 throughout busy.
- `start` pulsed at byte 500 and again with `done`: both ignored; the following `start` yields frame_id=01. 256 packets later frame_id wraps to 00.
- `rst_n` low at byte 1000: all outputs at reset values in the same cycle, with no `m_last` or `done`. Next `start` yields a complete 3080-byte packet with frame_id 00.

Source files
------------

// File: rtl/histo_readout.sv
// histo_readout
// Readout stage for the histogram accumulator. On a start pulse it holds the
// accumulator in read mode, sweeps every bin through the bin/data read port,
// and emits a byte packet over a valid/ready stream:
//   A5 5A frame_id | NUM_BINS x 3-byte counts (MSB first) |
//   32-bit sum of counts (MSB first) | 8-bit checksum (frame_id..last sum byte)
//
// Ports
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   start      : end-of-frame pulse, accepted only in IDLE
//   busy       : packet in progress
//   done       : one-cycle pulse after the checksum byte is accepted
//   hist_rw    : accumulator mode, 1 = accumulate, 0 = read
//   hist_bin   : bin address to the accumulator
//   hist_data  : count returned RD_LAT cycles after hist_bin changes
//   m_data     : stream byte
//   m_valid    : m_data valid
//   m_ready    : downstream accepts the byte
//   m_last     : marks the checksum byte
module histo_readout #(
    parameter int NUM_BINS = 1024,
    parameter int BIN_W    = 10,
    parameter int COUNT_W  = 24,
    parameter int RD_LAT   = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               hist_rw,
    output logic [BIN_W-1:0]   hist_bin,
    input  logic [COUNT_W-1:0] hist_data,
    output logic [7:0]         m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               m_last
);

    // Shared counter: header/send/tail byte index and fetch wait count.
    localparam int CNT_W = $clog2(RD_LAT + 4);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FETCH,
        S_SEND,
        S_TAIL,
        S_CSUM
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BIN_W-1:0]   bin_q, bin_d;
    logic [COUNT_W-1:0] count_q, count_d;
    logic [31:0]        sum_q, sum_d;
    logic [7:0]         csum_q, csum_d;
    logic [7:0]         fid_q, fid_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               done_q, done_d;

    logic               xfer;
    logic [7:0]         csum_add;

    assign xfer     = valid_q & m_ready;
    // Running checksum including the byte currently being transferred.
    assign csum_add = csum_q + data_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bin_d   = bin_q;
        count_d = count_q;
        sum_d   = sum_q;
        csum_d  = csum_q;
        fid_d   = fid_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A start coinciding with done is the tail of the previous frame.
                if (start && !done_q) begin
                    state_d = S_HDR;
                    cnt_d   = '0;
                    data_d  = 8'hA5;
                    valid_d = 1'b1;
                    sum_d   = '0;
                    csum_d  = '0;
                end
            end

            S_HDR: begin
                if (xfer) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(0)) begin
                        data_d = 8'h5A;
                    end else if (cnt_q == CNT_W'(1)) begin
                        data_d = fid_q;
                    end else begin
                        csum_d  = csum_add;
                        state_d = S_FETCH;
                        cnt_d   = '0;
                        bin_d   = '0;
                        valid_d = 1'b0;
                    end
                end
            end

            S_FETCH: begin
                // hist_bin was loaded on entry; the read data is due on the
                // edge that ends the RD_LAT-th fetch cycle.
                if (cnt_q == CNT_W'(RD_LAT - 1)) begin
                    count_d = hist_data;
                    sum_d   = sum_q + 32'(hist_data);
                    data_d  = hist_data[COUNT_W-1 -: 8];
                    valid_d = 1'b1;
                    state_d = S_SEND;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_SEND: begin
                if (xfer) begin
                    csum_d = csum_add;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(0)) begin
                        data_d = count_q[COUNT_W-9 -: 8];
                    end else if (cnt_q == CNT_W'(1)) begin
                        data_d = count_q[COUNT_W-17 -: 8];
                    end else if (bin_q == BIN_W'(NUM_BINS - 1)) begin
                        state_d = S_TAIL;
                        cnt_d   = '0;
                        data_d  = sum_q[31:24];
                    end else begin
                        state_d = S_FETCH;
                        cnt_d   = '0;
                        bin_d   = bin_q + BIN_W'(1);
                        valid_d = 1'b0;
                    end
                end
            end

            S_TAIL: begin
                if (xfer) begin
                    csum_d = csum_add;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(0)) begin
                        data_d = sum_q[23:16];
                    end else if (cnt_q == CNT_W'(1)) begin
                        data_d = sum_q[15:8];
                    end else if (cnt_q == CNT_W'(2)) begin
                        data_d = sum_q[7:0];
                    end else begin
                        state_d = S_CSUM;
                        data_d  = csum_add;
                        last_d  = 1'b1;
                    end
                end
            end

            S_CSUM: begin
                if (xfer) begin
                    state_d = S_IDLE;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                    fid_d   = fid_q + 8'd1;
                end
            end

            default: begin
                state_d = S_IDLE;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bin_q   <= '0;
            fid_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bin_q   <= bin_d;
            fid_q   <= fid_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Datapath accumulators are cleared on start acceptance, not by reset.
    always_ff @(posedge clk) begin
        count_q <= count_d;
        sum_q   <= sum_d;
        csum_q  <= csum_d;
    end

    assign busy     = (state_q != S_IDLE);
    assign hist_rw  = (state_q == S_IDLE);
    assign hist_bin = bin_q;
    assign m_data   = data_q;
    assign m_valid  = valid_q;
    assign m_last   = last_q;
    assign done     = done_q;

endmodule

// File: tb/tb_histo_readout.sv
module tb_histo_readout;

    localparam int NB      = 1024;
    localparam int PKT_LEN = 3080;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        busy, done, hist_rw, m_valid, m_ready, m_last;
    logic [9:0]  hist_bin;
    logic [23:0] hist_data;
    logic [7:0]  m_data;

    // Second, small instance used only for the frame_id wrap check.
    logic        start_s, busy_s, done_s, rw_s, valid_s, ready_s, last_s;
    logic [1:0]  bin_s;
    logic [23:0] hd_s;
    logic [7:0]  data_s;

    histo_readout #(.NUM_BINS(NB), .BIN_W(10), .COUNT_W(24), .RD_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .hist_rw(hist_rw), .hist_bin(hist_bin), .hist_data(hist_data),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last)
    );

    histo_readout #(.NUM_BINS(4), .BIN_W(2), .COUNT_W(24), .RD_LAT(2)) u_small (
        .clk(clk), .rst_n(rst_n), .start(start_s), .busy(busy_s), .done(done_s),
        .hist_rw(rw_s), .hist_bin(bin_s), .hist_data(hd_s),
        .m_data(data_s), .m_valid(valid_s), .m_ready(ready_s), .m_last(last_s)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Accumulator model: synchronous read, so data for a bin address set on
    // edge N is presented during the cycle after edge N+1 (RD_LAT = 2).
    logic [23:0] mem [NB];
    always @(posedge clk) begin
        hist_data <= mem[hist_bin];
        hd_s      <= {22'd0, bin_s};
    end

    int n_vec = 0;
    int n_err = 0;
    int rdy_pct = 100;
    int cyc_g = 0;

    always @(posedge clk) cyc_g <= cyc_g + 1;

    initial begin
        m_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1 m_ready = ($urandom_range(0, 99) < rdy_pct);
        end
    end

    // Stream monitor, sampled mid-cycle.
    logic [7:0] got_q [$];
    int   last_cnt = 0, last_pos = 0, last_cyc = 0;
    int   done_cnt = 0, done_cyc = 0;
    int   stall_bad = 0, rw_bad = 0, bin_bad = 0;
    int   pos = 0;
    bit   prev_stall = 0;
    logic [7:0] prev_data = 0;
    logic prev_last = 0;

    always @(negedge clk) begin
        if (m_valid && m_ready) begin
            got_q.push_back(m_data);
            if (pos >= 3 && pos <= 3074 && hist_bin != 10'((pos - 3) / 3)) bin_bad++;
            if (m_last) begin
                last_cnt++;
                last_pos = got_q.size() - 1;
                last_cyc = cyc_g;
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc_g;
        end
        if (rst_n && prev_stall && !(m_valid && m_data == prev_data && m_last == prev_last))
            stall_bad++;
        prev_stall = rst_n && m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (hist_rw == busy) rw_bad++;
        if (!busy) pos = 0;
        else if (m_valid && m_ready) pos++;
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fill(input int pat);
        for (int k = 0; k < NB; k++) begin
            case (pat)
                0:       mem[k] = 24'h0;
                1:       mem[k] = 24'(k);
                2:       mem[k] = 24'hFFFFFF;
                default: mem[k] = 24'($urandom);
            endcase
        end
    endtask

    // Reference packet built directly from the packet format.
    logic [7:0] exp_q [$];
    task automatic build_exp(input logic [7:0] id);
        logic [31:0] s;
        logic [7:0]  c;
        exp_q.delete();
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(id);
        s = 0;
        for (int k = 0; k < NB; k++) begin
            exp_q.push_back(mem[k][23:16]);
            exp_q.push_back(mem[k][15:8]);
            exp_q.push_back(mem[k][7:0]);
            s = s + {8'd0, mem[k]};
        end
        exp_q.push_back(s[31:24]);
        exp_q.push_back(s[23:16]);
        exp_q.push_back(s[15:8]);
        exp_q.push_back(s[7:0]);
        c = 0;
        for (int i = 2; i < exp_q.size(); i++) c = c + exp_q[i];
        exp_q.push_back(c);
    endtask

    task automatic run_packet(input int rdy, input bit inj, input int abort_at,
                              input logic [7:0] id, output logic [31:0] sum_o);
        int base, lc0, dc0, sb0, rb0, bb0, cycles, bad;
        bit fired;
        rdy_pct = rdy;
        build_exp(id);
        sum_o = 0;
        base = got_q.size();
        lc0 = last_cnt; dc0 = done_cnt; sb0 = stall_bad; rb0 = rw_bad; bb0 = bin_bad;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        chk("t1_busy", busy, 1);
        chk("t1_hist_rw", hist_rw, 0);
        chk("t1_m_valid", m_valid, 1);
        chk("t1_m_data", m_data, 8'hA5);
        cycles = 1;
        fired  = 0;
        while (!done && cycles < 30000) begin
            if (abort_at > 0 && got_q.size() - base >= abort_at) break;
            if (inj && !fired && got_q.size() - base >= 500) begin
                start = 1'b1;
                fired = 1;
            end
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            cycles++;
        end

        if (abort_at > 0) begin
            #2 rst_n = 1'b0;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_hist_rw", hist_rw, 1);
            chk("rst_hist_bin", hist_bin, 0);
            chk("rst_m_data", m_data, 0);
            chk("rst_m_valid", m_valid, 0);
            chk("rst_m_last", m_last, 0);
            repeat (3) @(negedge clk);
            chk("rst_no_last", last_cnt - lc0, 0);
            chk("rst_no_done", done_cnt - dc0, 0);
            #2 rst_n = 1'b1;
            return;
        end

        chk("done_seen", done, 1);
        if (rdy == 100) chk("done_latency", cycles, 5129);
        if (inj) begin
            start = 1'b1;               // same cycle as done
            @(posedge clk); #1 start = 1'b0;
            @(negedge clk);
            chk("start_with_done_ignored", busy, 0);
        end
        @(negedge clk);
        chk("pkt_len", got_q.size() - base, PKT_LEN);
        if (got_q.size() - base >= PKT_LEN) begin
            bad = PKT_LEN - 1;
            for (int i = 0; i < PKT_LEN; i++) begin
                if (got_q[base + i] !== exp_q[i]) begin
                    bad = i;
                    break;
                end
            end
            chk($sformatf("pkt_byte%0d", bad), got_q[base + bad], exp_q[bad]);
            chk("frame_id", got_q[base + 2], id);
            sum_o = {got_q[base + 3075], got_q[base + 3076], got_q[base + 3077], got_q[base + 3078]};
        end
        chk("m_last_count", last_cnt - lc0, 1);
        chk("m_last_pos", last_pos - base, PKT_LEN - 1);
        chk("done_count", done_cnt - dc0, 1);
        chk("done_after_last", done_cyc - last_cyc, 1);
        chk("stall_stable", stall_bad - sb0, 0);
        chk("hist_rw_vs_busy", rw_bad - rb0, 0);
        chk("hist_bin_seq", bin_bad - bb0, 0);
    endtask

    task automatic run_small(output logic [7:0] id, output logic [7:0] ck,
                             output int n, output int lasts);
        int cyc;
        logic [7:0] b [$];
        lasts = 0;
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        cyc = 0;
        do begin
            @(negedge clk);
            if (valid_s && ready_s) begin
                b.push_back(data_s);
                if (last_s) lasts++;
            end
            cyc++;
        end while (!done_s && cyc < 200);
        n  = b.size();
        id = (n > 2) ? b[2] : 8'h00;
        ck = (n > 0) ? b[n - 1] : 8'h00;
    endtask

    typedef struct {
        int          pat;
        int          rdy;
        bit          has_sum;
        logic [31:0] sum;
    } vec_t;

    initial begin
        vec_t        vecs [5];
        logic [7:0]  fid;
        logic [31:0] s;
        logic [7:0]  sid, sck;
        int          sn, sl;

        vecs[0] = '{pat: 0, rdy: 100, has_sum: 1, sum: 32'h00000000};
        vecs[1] = '{pat: 1, rdy: 100, has_sum: 1, sum: 32'h0007FE00};
        vecs[2] = '{pat: 2, rdy: 100, has_sum: 1, sum: 32'hFFFFFC00};
        vecs[3] = '{pat: 1, rdy: 50,  has_sum: 1, sum: 32'h0007FE00};
        vecs[4] = '{pat: 3, rdy: 70,  has_sum: 0, sum: 32'h0};

        rst_n   = 1'b0;
        start   = 1'b0;
        start_s = 1'b0;
        ready_s = 1'b1;
        fill(0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_hist_rw", hist_rw, 1);
        chk("reset_hist_bin", hist_bin, 0);
        chk("reset_m_data", m_data, 0);
        chk("reset_m_valid", m_valid, 0);
        chk("reset_m_last", m_last, 0);
        rst_n = 1'b1;
        fid = 8'h00;

        // Stray starts at byte 500 and with done; next packet must carry id 01.
        fill(1);
        run_packet(100, 1, 0, fid, s);
        fid = fid + 8'd1;

        for (int i = 0; i < 5; i++) begin
            fill(vecs[i].pat);
            run_packet(vecs[i].rdy, 0, 0, fid, s);
            if (vecs[i].has_sum) chk($sformatf("sum_field_v%0d", i), s, vecs[i].sum);
            fid = fid + 8'd1;
        end

        // Abort mid-packet, then a fresh packet starts over at frame_id 00.
        fill(1);
        run_packet(100, 0, 1000, fid, s);
        fid = 8'h00;
        run_packet(100, 0, 0, fid, s);
        chk("sum_after_reset", s, 32'h0007FE00);

        // frame_id wrap on the 4-bin instance; counts 0..3 give checksum id+12.
        for (int p = 0; p <= 256; p++) begin
            run_small(sid, sck, sn, sl);
            if (p == 255) begin
                chk("small_len", sn, 20);
                chk("small_id_255", sid, 8'hFF);
                chk("small_csum_255", sck, 8'h0B);
                chk("small_last", sl, 1);
            end
            if (p == 256) begin
                chk("small_id_wrap", sid, 8'h00);
                chk("small_csum_wrap", sck, 8'h0C);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
